// File: rtl/if_fetch_responder_pkg.sv
// Shared constants and helpers for the instruction-fetch responder.
package if_fetch_responder_pkg;

    // Default widths: 64-bit addresses, one 64-bit line holding two instructions.
    localparam int          ADDR_W_DEF   = 64;
    localparam int          LINE_W_DEF   = 64;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // Fill FSM encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Pick one 32-bit instruction out of a 64-bit line using address bit 2.
    function automatic logic [31:0] sel_word(input logic [63:0] line, input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/if_fetch_responder_line_buf.sv
// Single-line instruction buffer: valid/tag/data with fill and invalidate,
// combinational hit detection and word select.
module if_fetch_responder_line_buf
    import if_fetch_responder_pkg::*;
#(
    parameter int TAG_W  = 61,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_i,
    input  logic              fill_valid_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_data_i,
    input  logic              inv_i,
    input  logic              lookup_en_i,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    input  logic              lookup_word_i,
    output logic              hit_o,
    output logic [31:0]       word_o
);

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [LINE_W-1:0] data_q,  data_d;

    // Next-state: a fill overrides an invalidate; the fill itself carries the
    // valid bit so a fill killed by fence.i lands with valid cleared.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = fill_valid_i;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end else if (inv_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    // Same-cycle lookup against the stored line.
    always_comb begin
        hit_o  = lookup_en_i & valid_q & (lookup_tag_i == tag_q);
        word_o = sel_word(data_q, lookup_word_i);
    end

endmodule

// File: rtl/if_fetch_responder.sv
// Instruction-fetch responder: serves hits from a one-line buffer in the same
// cycle and refills the line from instruction memory via req/ack on a miss.
module if_fetch_responder
    import if_fetch_responder_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          LINE_W   = LINE_W_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_en_i,
    input  logic              inv_i,
    output logic [31:0]       inst_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    localparam int TAG_W = ADDR_W - 3;

    logic [0:0]        state_q, state_d;
    logic              kill_q,  kill_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    logic              hit;
    logic [31:0]       buf_word;
    logic              fill;
    logic              fill_valid;
    logic              busy;

    // Byte offset within an instruction is meaningless for 32-bit fetch.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_i[1:0];

    if_fetch_responder_line_buf #(
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_line_buf (
        .clk           (clk),
        .rst           (rst),
        .fill_i        (fill),
        .fill_valid_i  (fill_valid),
        .fill_tag_i    (addr_q[ADDR_W-1:3]),
        .fill_data_i   (mem_rdata_i),
        .inv_i         (inv_i),
        .lookup_en_i   (pc_en_i & ~rst),
        .lookup_tag_i  (pc_i[ADDR_W-1:3]),
        .lookup_word_i (pc_i[2]),
        .hit_o         (hit),
        .word_o        (buf_word)
    );

    assign busy = (state_q == ST_BUSY);

    // Fetch-side outputs; IF is held for the whole fill while it keeps fetching.
    always_comb begin
        inst_o  = hit ? buf_word : NOP_INST;
        stall_o = ~rst & pc_en_i & (~hit | busy);
    end

    // Miss/fill FSM. The request is never cancelled: a pc change during BUSY
    // just gets re-evaluated once the fill lands. fence.i during a fill marks
    // it killed so the incoming line is stored invalid.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        addr_d     = addr_q;
        fill       = 1'b0;
        fill_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pc_en_i & ~hit) begin
                    state_d = ST_BUSY;
                    addr_d  = {pc_i[ADDR_W-1:3], 3'b000};
                    kill_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    fill       = 1'b1;
                    fill_valid = ~kill_q & ~inv_i;
                    kill_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else if (inv_i) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and latched line address; async reset may abort a fill at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
        end
    end

    // Request is the registered BUSY state, so it rises the cycle after the
    // miss and drops the cycle after ack.
    always_comb begin
        mem_req_o  = busy;
        mem_addr_o = addr_q;
    end

endmodule
